// File: rtl/fence_area_calc.sv
// -----------------------------------------------------------------------------
// fence_area_calc
//   Takes the N fence vertices that the upstream sorter streams out in
//   counter-clockwise order. From them it computes twice the enclosed polygon
//   area using the shoelace formula, at one cross-product step per cycle.
//   It reports |2*area| together with an orientation flag, and marks the
//   result with a one-cycle out_valid pulse.
//
// Parameters
//   N      number of vertices per fence (>= 3)
//   W      vertex coordinate width, two's complement
//   ACC_W  accumulator / result width (>= 2*W + ceil(log2 N) + 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   vertex beat valid (no backpressure, gaps allowed)
//   in_x/in_y  vertex coordinates, signed
//   busy       high while a fence is being evaluated (beats are dropped)
//   out_valid  one-cycle result strobe, one per complete fence
//   area2      |2*area|, unsigned, held until the next result
//   cw         1 = vertices were clockwise (signed sum negative)
// -----------------------------------------------------------------------------
module fence_area_calc #(
    parameter int N     = 6,
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    output logic                busy,
    output logic                out_valid,
    output logic [ACC_W-1:0]    area2,
    output logic                cw
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         step_q, step_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     fin_q, fin_d;
    logic                     out_valid_q;
    logic [ACC_W-1:0]         area2_q;
    logic                     cw_q;
    logic                     wr_en_s;

    logic signed [W-1:0]      x_mem_q [N];
    logic signed [W-1:0]      y_mem_q [N];

    logic [IDX_W-1:0]         k1_s;
    logic signed [ACC_W-1:0]  cross_s;

    // Sign-extend a coordinate to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] v);
        return {{(ACC_W - W){v[W-1]}}, v};
    endfunction

    // Magnitude of the signed accumulator; -2^(ACC_W-1) cannot occur for legal ACC_W.
    function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] neg;
        neg = -v;
        if (v[ACC_W-1]) begin
            return $unsigned(neg);
        end else begin
            return $unsigned(v);
        end
    endfunction

    // Shoelace term for the current step; the last vertex pairs with vertex 0.
    always_comb begin
        k1_s    = (step_q == LAST_IDX) ? {IDX_W{1'b0}} : (step_q + IDX_W'(1));
        cross_s = (sext(x_mem_q[step_q]) * sext(y_mem_q[k1_s]))
                - (sext(x_mem_q[k1_s])   * sext(y_mem_q[step_q]));
    end

    // Next-state logic: collect N beats, run N accumulate steps, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        acc_d   = acc_q;
        fin_d   = 1'b0;
        wr_en_s = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (in_valid) begin
                    wr_en_s = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IDX_W{1'b0}};
                        step_d  = {IDX_W{1'b0}};
                        acc_d   = {ACC_W{1'b0}};
                        state_d = ST_CALC;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_CALC: begin
                acc_d = acc_q + cross_s;
                if (step_q == LAST_IDX) begin
                    step_d  = {IDX_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                fin_d   = 1'b1;
                state_d = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = {IDX_W{1'b0}};
                step_d  = {IDX_W{1'b0}};
                acc_d   = {ACC_W{1'b0}};
            end
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_COLLECT;
            idx_q   <= {IDX_W{1'b0}};
            step_q  <= {IDX_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            fin_q   <= fin_d;
        end
    end

    // Result registers. The DONE strobe is staged once more through fin_q, so
    // out_valid lands N+2 edges after the last vertex. acc_q is still stable
    // at that point because it is only cleared when the next fence completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            area2_q     <= {ACC_W{1'b0}};
            cw_q        <= 1'b0;
        end else begin
            out_valid_q <= fin_q;
            if (fin_q) begin
                area2_q <= magnitude(acc_q);
                cw_q    <= acc_q[ACC_W-1];
            end else begin
                area2_q <= area2_q;
                cw_q    <= cw_q;
            end
        end
    end

    // Vertex storage; contents are irrelevant after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            x_mem_q[idx_q] <= in_x;
            y_mem_q[idx_q] <= in_y;
        end
    end

    assign busy      = (state_q != ST_COLLECT);
    assign out_valid = out_valid_q;
    assign area2     = area2_q;
    assign cw        = cw_q;

endmodule

// File: tb/tb_fence_area_calc.sv
module tb_fence_area_calc;

    localparam int N     = 6;
    localparam int W     = 8;
    localparam int ACC_W = 20;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic signed [W-1:0] in_x;
    logic signed [W-1:0] in_y;
    logic                busy;
    logic                out_valid;
    logic [ACC_W-1:0]    area2;
    logic                cw;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_cap;
    int last_a;
    int last_b;

    typedef struct {
        int               c;
        logic [ACC_W-1:0] a;
        logic             cw;
    } res_t;

    res_t res_q[$];
    res_t mon_r;

    // Fence tables: 0 = CCW test shape, 1 = coordinate extremes, 2 = collinear.
    int vx[3][6] = '{'{0, 4, 4, 2, 0, 0}, '{0, 127, 127, 0, -128, -128}, '{0, 1, 2, 3, 4, 5}};
    int vy[3][6] = '{'{0, 0, 4, 6, 4, 2}, '{0, 0, 127, 127, 127, 0},     '{0, 2, 4, 6, 8, 10}};

    fence_area_calc #(.N(N), .W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .busy      (busy),
        .out_valid (out_valid),
        .area2     (area2),
        .cw        (cw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to time results.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle on which out_valid is seen high.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            mon_r.c  = cyc;
            mon_r.a  = area2;
            mon_r.cw = cw;
            res_q.push_back(mon_r);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Set the inputs on the falling edge; the next rising edge samples them.
    task automatic drive(input logic v, input int x, input int y);
        @(negedge clk);
        in_valid = v;
        in_x     = W'(x);
        in_y     = W'(y);
    endtask

    task automatic send_fence(input int f, input bit rev, input int gap);
        for (int i = 0; i < N; i++) begin
            int j;
            j = rev ? (N - 1 - i) : i;
            drive(1'b1, vx[f][j], vy[f][j]);
            last_cap = cyc + 1;
            for (int g = 0; g < gap; g++) drive(1'b0, 0, 0);
        end
        drive(1'b0, 0, 0);
    endtask

    task automatic run_check(input string tag, input int exp_area, input int exp_cw);
        for (int i = 0; i < 14; i++) drive(1'b0, 0, 0);
        check_val({tag, "_count"}, 32'(res_q.size()), 32'd1);
        if (res_q.size() >= 1) begin
            check_val({tag, "_latency"}, 32'(res_q[0].c - last_cap), 32'd8);
            check_val({tag, "_area2"}, 32'(res_q[0].a), 32'(exp_area));
            check_val({tag, "_cw"}, 32'(res_q[0].cw), 32'(exp_cw));
        end
        check_val({tag, "_held"}, 32'(area2), 32'(exp_area));
        check_val({tag, "_ov_low"}, 32'(out_valid), 32'd0);
        res_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_area2", 32'(area2), 32'd0);
        check_val("rst_cw", 32'(cw), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // 1: CCW fence
        send_fence(0, 1'b0, 0);
        run_check("t1", 40, 0);

        // 2: same fence reversed (clockwise)
        send_fence(0, 1'b1, 0);
        run_check("t2", 40, 1);

        // 3: coordinate extremes
        send_fence(1, 1'b0, 0);
        run_check("t3", 64770, 0);

        // 4: collinear points
        send_fence(2, 1'b0, 0);
        run_check("t4", 0, 0);

        // 5: partial fence discarded by reset, then a gapped fence
        for (int i = 0; i < 3; i++) drive(1'b1, vx[1][i], vy[1][i]);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("t5_rst_ov", 32'(out_valid), 32'd0);
            check_val("t5_rst_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        send_fence(0, 1'b0, 2);
        run_check("t5", 40, 0);

        // 6: in_valid held high through CALC/DONE; garbage beats are dropped
        for (int i = 0; i < N; i++) drive(1'b1, vx[0][i], vy[0][i]);
        last_a = cyc + 1;
        for (int i = 0; i < N + 1; i++) begin
            drive(1'b1, 99, -99);
            check_val("t6_busy", 32'(busy), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
            drive(1'b1, vx[0][N-1-i], vy[0][N-1-i]);
            if (i == 0) check_val("t6_idle", 32'(busy), 32'd0);
        end
        last_b = cyc + 1;
        for (int i = 0; i < 14; i++) drive(1'b0, 0, 0);
        check_val("t6_count", 32'(res_q.size()), 32'd2);
        if (res_q.size() >= 2) begin
            check_val("t6_lat0", 32'(res_q[0].c - last_a), 32'd8);
            check_val("t6_area0", 32'(res_q[0].a), 32'd40);
            check_val("t6_cw0", 32'(res_q[0].cw), 32'd0);
            check_val("t6_lat1", 32'(res_q[1].c - last_b), 32'd8);
            check_val("t6_area1", 32'(res_q[1].a), 32'd40);
            check_val("t6_cw1", 32'(res_q[1].cw), 32'd1);
        end
        res_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
